// File: rtl/video_stream_if.sv
// Valid/ready video stream bundle: pixel data with start-of-frame (tuser)
// and end-of-line (tlast) sideband.
interface video_stream_if #(
  parameter int D_WIDTH = 8
) ();
  logic               valid;
  logic               ready;
  logic [D_WIDTH-1:0] data;
  logic               tlast;
  logic               tuser;

  modport master (output valid, data, tlast, tuser, input ready);
  modport slave  (input valid, data, tlast, tuser, output ready);
endinterface

// File: rtl/video_stream_source.sv
// Raster test-pattern source: emits H_ACTIVE x V_ACTIVE frames of
// (x + 2*y + frame_count) with idle gaps after each line and frame.
module video_stream_source #(
  parameter int D_WIDTH  = 8,
  parameter int H_ACTIVE = 8,
  parameter int V_ACTIVE = 4,
  parameter int H_BLANK  = 2,
  parameter int V_BLANK  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  video_stream_if.master         down,
  output logic                   frame_done,
  output logic [15:0]            frame_count
);

  localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int B_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BW    = (B_MAX > 1) ? $clog2(B_MAX) : 1;

  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] HB_LOAD = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [BW-1:0] VB_LOAD = BW'((V_BLANK > 0) ? V_BLANK - 1 : 0);
  localparam logic          FIRST_IS_LAST = (H_ACTIVE == 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_VBLANK
  } state_t;

  state_t             r_state;
  logic [XW-1:0]      r_x;
  logic [YW-1:0]      r_y;
  logic [BW-1:0]      r_blank;
  logic [15:0]        r_frame_count;
  logic               r_frame_done;
  logic               r_valid;
  logic [D_WIDTH-1:0] r_data;
  logic               r_tlast;
  logic               r_tuser;

  logic               w_xfer;
  logic               w_x_last;
  logic               w_y_last;
  logic [XW-1:0]      w_x_next;
  logic [YW-1:0]      w_y_next;
  logic [15:0]        w_fc_next;

  assign w_xfer    = r_valid & down.ready;
  assign w_x_last  = (r_x == X_LAST);
  assign w_y_last  = (r_y == Y_LAST);
  assign w_x_next  = r_x + 1'b1;
  assign w_y_next  = r_y + 1'b1;
  assign w_fc_next = r_frame_count + 16'd1;

  function automatic logic [D_WIDTH-1:0] f_pixel(input logic [XW-1:0] x,
                                                 input logic [YW-1:0] y,
                                                 input logic [15:0]   fc);
    logic [31:0] s;
    s = 32'(x) + (32'(y) << 1) + 32'(fc);
    return s[D_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_x           <= '0;
      r_y           <= '0;
      r_blank       <= '0;
      r_frame_count <= '0;
      r_frame_done  <= 1'b0;
      r_valid       <= 1'b0;
      r_data        <= '0;
      r_tlast       <= 1'b0;
      r_tuser       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_valid <= 1'b1;
            r_data  <= f_pixel('0, '0, r_frame_count);
            r_tuser <= 1'b1;
            r_tlast <= FIRST_IS_LAST;
            r_state <= S_ACTIVE;
          end
        end

        S_ACTIVE: begin
          if (w_xfer) begin
            if (!w_x_last) begin
              r_x     <= w_x_next;
              r_data  <= f_pixel(w_x_next, r_y, r_frame_count);
              r_tuser <= 1'b0;
              r_tlast <= (w_x_next == X_LAST);
            end else if (!w_y_last) begin
              r_x <= '0;
              r_y <= w_y_next;
              if (H_BLANK > 0) begin
                r_valid <= 1'b0;
                r_blank <= HB_LOAD;
                r_state <= S_HBLANK;
              end else begin
                r_data  <= f_pixel('0, w_y_next, r_frame_count);
                r_tuser <= 1'b0;
                r_tlast <= FIRST_IS_LAST;
              end
            end else begin
              r_x           <= '0;
              r_y           <= '0;
              r_frame_count <= w_fc_next;
              r_frame_done  <= 1'b1;
              if (V_BLANK > 0) begin
                r_valid <= 1'b0;
                r_blank <= VB_LOAD;
                r_state <= S_VBLANK;
              end else if (enable) begin
                // Zero vertical blank: frame boundary is the transfer itself
                r_data  <= f_pixel('0, '0, w_fc_next);
                r_tuser <= 1'b1;
                r_tlast <= FIRST_IS_LAST;
              end else begin
                r_valid <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
        end

        S_HBLANK: begin
          if (r_blank == '0) begin
            r_valid <= 1'b1;
            r_data  <= f_pixel('0, r_y, r_frame_count);
            r_tuser <= 1'b0;
            r_tlast <= FIRST_IS_LAST;
            r_state <= S_ACTIVE;
          end else begin
            r_blank <= r_blank - 1'b1;
          end
        end

        S_VBLANK: begin
          if (r_blank == '0) begin
            if (enable) begin
              r_valid <= 1'b1;
              r_data  <= f_pixel('0, '0, r_frame_count);
              r_tuser <= 1'b1;
              r_tlast <= FIRST_IS_LAST;
              r_state <= S_ACTIVE;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_blank <= r_blank - 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign down.valid  = r_valid;
  assign down.data   = r_data;
  assign down.tlast  = r_tlast;
  assign down.tuser  = r_tuser;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_video_stream_source.sv
// Directed bench for video_stream_source: a blanked 4x2 instance (A) and a
// zero-blank 4x2 instance (B).
module tb_video_stream_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, done_a;
  logic [15:0] fc_a;
  logic        rst_b, en_b, done_b;
  logic [15:0] fc_b;

  video_stream_if #(.D_WIDTH(8)) if_a ();
  video_stream_if #(.D_WIDTH(8)) if_b ();

  video_stream_source #(
    .D_WIDTH(8), .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(2), .V_BLANK(3)
  ) dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .down(if_a.master),
    .frame_done(done_a), .frame_count(fc_a)
  );

  video_stream_source #(
    .D_WIDTH(8), .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(0), .V_BLANK(0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .down(if_b.master),
    .frame_done(done_b), .frame_count(fc_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        v;
    logic [7:0]  d;
    logic        tl;
    logic        tu;
    logic        dn;
    logic [15:0] fc;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input int en, rdy, v, d, tl, tu, dn, fc);
    vec_t r;
    r.en  = 1'(en);
    r.rdy = 1'(rdy);
    r.v   = 1'(v);
    r.d   = 8'(d);
    r.tl  = 1'(tl);
    r.tu  = 1'(tu);
    r.dn  = 1'(dn);
    r.fc  = 16'(fc);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pixel(input int x, input int y, input int f);
    return 8'((x + 2 * y + f) % 256);
  endfunction

  function automatic logic [27:0] pack_a();
    return {if_a.valid, if_a.tuser, if_a.tlast, done_a, if_a.data, fc_a};
  endfunction

  function automatic logic [27:0] pack_b();
    return {if_b.valid, if_b.tuser, if_b.tlast, done_b, if_b.data, fc_b};
  endfunction

  initial begin
    logic [10:0] cur, prev;
    logic        prev_stall;
    logic        r;
    int          idx, cyc, x, y, f, p;
    logic        seen;

    rst_a = 1'b1; en_a = 1'b0; if_a.ready = 1'b0;
    rst_b = 1'b1; en_b = 1'b0; if_b.ready = 1'b0;

    // Frame 0 and the start of frame 1 with ready held high
    vecs[0]  = mk(1, 1, 1, 0, 0, 1, 0, 0);
    vecs[1]  = mk(1, 1, 1, 1, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 1, 2, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 1, 3, 1, 0, 0, 0);
    vecs[4]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 1, 1, 2, 0, 0, 0, 0);
    vecs[7]  = mk(1, 1, 1, 3, 0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 1, 4, 0, 0, 0, 0);
    vecs[9]  = mk(1, 1, 1, 5, 1, 0, 0, 0);
    vecs[10] = mk(1, 1, 0, 0, 0, 0, 1, 1);
    vecs[11] = mk(1, 1, 0, 0, 0, 0, 0, 1);
    vecs[12] = mk(1, 1, 0, 0, 0, 0, 0, 1);
    vecs[13] = mk(1, 1, 1, 1, 0, 1, 0, 1);

    step();
    step();
    check("reset_a", 64'(pack_a()), 64'd0);
    check("reset_b", 64'(pack_b()), 64'd0);
    rst_a = 1'b0;
    step();
    check("idle_no_enable", 64'(pack_a()), 64'd0);

    for (int i = 0; i < 14; i++) begin
      en_a       = vecs[i].en;
      if_a.ready = vecs[i].rdy;
      step();
      if (vecs[i].v)
        check($sformatf("vec%0d", i), 64'(pack_a()),
              64'({vecs[i].v, vecs[i].tu, vecs[i].tl, vecs[i].dn, vecs[i].d, vecs[i].fc}));
      else
        check($sformatf("vec%0d_blank", i), 64'({if_a.valid, done_a, fc_a}),
              64'({vecs[i].v, vecs[i].dn, vecs[i].fc}));
    end

    // Random ready over three frames with a scoreboard and stall stability
    rst_a = 1'b1; step(); rst_a = 1'b0;
    en_a = 1'b1;
    idx = 0; cyc = 0; prev_stall = 1'b0; prev = '0;
    while (idx < 24 && cyc < 2000) begin
      r = 1'($urandom_range(0, 1));
      if_a.ready = r;
      cur = {if_a.valid, if_a.tuser, if_a.tlast, if_a.data};
      if (prev_stall) check("stall_hold", 64'(cur), 64'(prev));
      if (if_a.valid && r) begin
        f = idx / 8; p = idx % 8; y = p / 4; x = p % 4;
        check($sformatf("rand_px%0d", idx), 64'({if_a.tuser, if_a.tlast, if_a.data}),
              64'({(x == 0 && y == 0), (x == 3), pixel(x, y, f)}));
        idx++;
      end
      prev_stall = if_a.valid && !r;
      prev = cur;
      step();
      cyc++;
    end
    if (idx < 24) check("rand_timeout", 64'(idx), 64'd24);
    check("rand_fc", 64'(fc_a), 64'd3);

    // Back-pressure on the tlast pixel of line 0
    rst_a = 1'b1; if_a.ready = 1'b1; en_a = 1'b1;
    step(); rst_a = 1'b0;
    step(); step(); step(); step();
    check("tlast_presented", 64'({if_a.valid, if_a.tlast, if_a.data}), 64'({1'b1, 1'b1, 8'd3}));
    if_a.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("tlast_hold%0d", i), 64'({if_a.valid, if_a.tlast, if_a.data}),
            64'({1'b1, 1'b1, 8'd3}));
    end
    if_a.ready = 1'b1;
    step();
    check("hblank_1", 64'(if_a.valid), 64'd0);
    step();
    check("hblank_2", 64'(if_a.valid), 64'd0);
    step();
    check("line1_start", 64'({if_a.valid, if_a.tuser, if_a.data}), 64'({1'b1, 1'b0, 8'd2}));

    // Enable dropped mid-frame: frame completes, then IDLE
    rst_a = 1'b1; step(); rst_a = 1'b0;
    en_a = 1'b1; if_a.ready = 1'b1;
    step();
    en_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      if (done_a) seen = 1'b1;
    end
    check("endrop_done", 64'({seen, fc_a}), 64'({1'b1, 16'd1}));
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("endrop_idle%0d", i), 64'(if_a.valid), 64'd0);
    end
    en_a = 1'b1;
    step();
    check("reenable", 64'({if_a.valid, if_a.tuser, if_a.data, fc_a}),
          64'({1'b1, 1'b1, 8'd1, 16'd1}));

    // Reset on the third pixel of a frame
    step(); step();
    check("third_px", 64'({if_a.valid, if_a.data}), 64'({1'b1, 8'd3}));
    rst_a = 1'b1;
    step();
    check("midframe_reset", 64'(pack_a()), 64'd0);
    rst_a = 1'b0;
    step();
    check("restart", 64'(pack_a()), 64'({1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 16'd0}));

    // Zero-blank instance: continuous valid across line and frame edges
    en_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b1; if_b.ready = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      f = i / 8; p = i % 8; y = p / 4; x = p % 4;
      check($sformatf("noblank%0d", i), 64'({if_b.valid, if_b.tuser, if_b.tlast, if_b.data}),
            64'({1'b1, (x == 0 && y == 0), (x == 3), pixel(x, y, f)}));
      step();
    end
    check("noblank_fc", 64'(fc_b), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_stream_source.md
Name: video_stream_source

Overview:
- AXI4-Stream video transmitter: generates raster frames of H_ACTIVE x V_ACTIVE pixels with a deterministic test pattern.
- Drives the upstream end of the valid/ready/tlast/tuser interface that the downscaler pipeline registers consume.
- tuser marks start-of-frame; tlast marks end-of-line.
- Inserts programmable idle gaps (valid low) after each line and after each frame, so stalls and bubbles can be exercised.

Parameters:
- D_WIDTH, 8: pixel data width.
- H_ACTIVE, 8: pixels per line, >=1.
- V_ACTIVE, 4: lines per frame, >=1.
- H_BLANK, 2: idle cycles after each non-final line, >=0.
- V_BLANK, 3: idle cycles after the final line of a frame, >=0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  allow frame start; sampled only at frame boundaries
- down_valid  out  1  pixel valid
- down_ready  in  1  downstream ready
- down_data  out  D_WIDTH  pixel value
- down_tlast  out  1  last pixel of line
- down_tuser  out  1  first pixel of frame
- frame_done  out  1  one-cycle pulse after the final pixel of a frame is accepted
- frame_count  out  16  count of completed frames, wraps at 2^16

Behaviour:
- All outputs are registered. Reset values: down_valid=0, down_data=0, down_tlast=0, down_tuser=0, frame_done=0, frame_count=0. After reset the FSM is in IDLE with x=0, y=0.
- Handshake is AXI-compliant:
  - Transfer occurs when down_valid & down_ready.
  - down_valid never depends combinationally on down_ready.
  - Once asserted, down_valid, down_data, down_tlast and down_tuser hold stable until the transfer.
- Pixel value: down_data = (x + 2*y + frame_count) mod 2^D_WIDTH.
  - x is the column, 0..H_ACTIVE-1; y is the line, 0..V_ACTIVE-1.
  - down_tuser=1 only for x=0,y=0. down_tlast=1 only for x=H_ACTIVE-1.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE: down_valid=0. If enable=1 at cycle M, pixel (0,0) is presented with down_valid=1 at M+1 (ACTIVE).
- ACTIVE: on a transfer at cycle N:
  - If x<H_ACTIVE-1: next pixel of the same line is presented at N+1 (back-to-back, no bubble).
  - If x=H_ACTIVE-1 and y<V_ACTIVE-1:
    - H_BLANK>0: HBLANK. down_valid=0 for cycles N+1..N+H_BLANK; pixel (0,y+1) valid at N+H_BLANK+1.
    - H_BLANK=0: pixel (0,y+1) valid at N+1.
  - If x=H_ACTIVE-1 and y=V_ACTIVE-1 (end of frame):
    - frame_count increments (visible at N+1); frame_done=1 at N+1 only.
    - x and y reset to 0.
    - V_BLANK>0: VBLANK with down_valid=0 for cycles N+1..N+V_BLANK.
- End of VBLANK: enable is sampled at cycle N+V_BLANK (or at cycle N when V_BLANK=0).
  - enable=1: new frame pixel (0,0) with tuser=1 valid at the next cycle. Its pattern uses the updated frame_count.
  - enable=0: go to IDLE.
- enable deassertion mid-frame has no effect; the current frame always completes.
- No transfer while down_ready=0: state, counters and outputs hold, including at a line or frame end.
- Blank counters run regardless of down_ready.
- Reset mid-frame: the next cycle shows reset values. No partial-frame completion; frame_count clears.
- Degenerate sizes:
  - H_ACTIVE=1: every pixel has tlast=1.
  - H_ACTIVE=1 and V_ACTIVE=1: the single pixel has tuser=1 and tlast=1 together.
- Counter widths: x and y counters are sized with $clog2 of their limits, minimum 1 bit. Blank counters are sized for max(H_BLANK,V_BLANK), minimum 1 bit.

Test Plan:
- Reset, then enable=1 with down_ready=1 (H_ACTIVE=4,V_ACTIVE=2,H_BLANK=2,V_BLANK=3):
  - Line 0 data 0,1,2,3 with tuser on data 0 and tlast on data 3.
  - 2 bubble cycles, then line 1 data 2,3,4,5.
  - frame_done pulse, 3 bubble cycles.
  - Frame 1 starts with data 1, tuser=1; frame_count=1.
- Random down_ready (50%) over 3 frames: outputs stay stable while valid & ~ready. Received sequence matches the pattern exactly, with 8 pixels per frame and frame_count=3 at the end.
- down_ready=0 held on the tlast pixel of line 0 for 5 cycles: valid, data=3 and tlast hold. HBLANK starts only after the transfer.
- enable dropped during line 0: frame completes, then IDLE with valid=0. Re-asserting enable at cycle M gives a tuser pixel at M+1.
- H_BLANK=0, V_BLANK=0, enable=1, ready=1: continuous valid with no bubbles across line and frame boundaries. tuser recurs every 8 transfers.
- rst asserted on the 3rd pixel of a frame: all outputs 0 next cycle. After release with enable=1, the frame restarts at pixel (0,0), data 0, tuser=1, frame_count=0.
